mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared dual-bank operand memory (DATA_WIDTH x 2^ADDR_WIDTH per bank, banks selected by M_Sel) in the Booth radix-8 multiplier datapath.
- Port A is the operand loader; port B is the multiplier operand fetch.
- Round-robin arbitration serialises single-word read/write transactions, drives the memory control pins and returns read data with a one-cycle acknowledge.

Parameters:
- DATA_WIDTH, 9, memory word width
- ADDR_WIDTH, 4, memory address width

Ports:
- Clk  input  1  system clock, rising edge
- Rst_n  input  1  synchronous, active-low reset
- A_Req  input  1  port A request; held with command until A_Ack
- A_We  input  1  port A: 1 = write, 0 = read
- A_Sel  input  1  port A bank select
- A_Addr  input  ADDR_WIDTH  port A address
- A_Wdata  input  DATA_WIDTH  port A write data
- A_Ack  output  1  port A transaction-done pulse, one cycle
- B_Req, B_We, B_Sel, B_Addr, B_Wdata, B_Ack  as port A, for port B
- Rdata  output  DATA_WIDTH  read data; valid in the cycle the granted Ack is high
- Busy  output  1  high whenever FSM is not IDLE
- Addr  output  ADDR_WIDTH  memory address
- Data_In  output  DATA_WIDTH  memory write data
- W_En  output  1  memory write enable
- M_Sel  output  1  memory bank select
- Data1_O  input  DATA_WIDTH  bank 0 read data
- Data2_O  input  DATA_WIDTH  bank 1 read data

Behaviour:
- Memory contract: write on rising Clk edge while W_En=1. Read data for Addr/M_Sel appears on Data1_O (M_Sel=0) or Data2_O (M_Sel=1) one cycle after Addr is driven.
- All outputs are registered.
- Reset (Rst_n=0 at rising edge) sets: state IDLE; A_Ack, B_Ack, W_En, Busy, M_Sel = 0; Addr, Data_In, Rdata = 0; Last_Gnt = B, so A wins the first contention.
- Reset mid-transaction aborts it with no Ack. An in-flight W_En is dropped at the reset edge.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - No Req: stay in IDLE.
  - Any Req: arbitrate. Only one requesting port wins. If both request, the port not equal to Last_Gnt wins.
  - Latch the winner's We/Sel/Addr/Wdata into Addr/M_Sel/Data_In. Set W_En = We. Update Last_Gnt. Go to ISSUE.
- ISSUE: memory sees the command.
  - Write: W_En drops to 0 at the next edge; go to ACK.
  - Read: W_En stays 0; go to WAIT.
- WAIT: capture Data1_O if M_Sel=0, else Data2_O, into Rdata; go to ACK.
- ACK: granted port's Ack=1 for exactly one cycle; go to IDLE. Addr/M_Sel/Data_In hold their last values until the next grant.
- Latency, counted from the edge sampling Req in IDLE (edge 0):
  - Write: W_En high cycle 1; Ack high cycle 2.
  - Read: Ack and valid Rdata cycle 3.
  - Minimum period back-to-back: write 3 cycles, read 4 cycles.
- Req still high in the IDLE after its ACK counts as a new request. With both requesting, the other port wins, so neither port can win twice in a row under contention.
- Req dropped before Ack: the transaction already latched completes and Ack still pulses. Commands are latched only in IDLE, so later changes to inputs are ignored.
- Never both Acks high. Busy=1 in ISSUE, WAIT, ACK.
- Rdata is unchanged by write transactions.
- Addr is modulo 2^ADDR_WIDTH; no range check.

Test Plan:
- Reset then idle: hold Rst_n=0 2 cycles, no Req -> all outputs 0, Busy=0, W_En never asserted.
- Single write then read:
  - A writes 9'd10 to Sel=0, Addr=3 -> W_En=1 exactly one cycle with Addr=3, Data_In=10; A_Ack 2 cycles after grant.
  - A then reads Sel=0, Addr=3 -> Rdata=10 with A_Ack 3 cycles after grant.
- Bank select: B writes 9'h1FF to Sel=1, Addr=15; B reads it -> Rdata=9'h1FF sourced from Data2_O; a Sel=0 read of Addr=15 returns the bank-0 value.
- Contention:
  - A and B request simultaneously out of reset -> A served first, then B.
  - Both hold Req for 4 transactions -> grant order A,B,A,B; Acks never overlap.
- Held Req with single requester: B holds a read Req for 3 transactions -> B_Ack every 4 cycles, Busy low for exactly 1 cycle between them.
- Reset mid-read: assert Rst_n=0 while in WAIT -> no Ack, Rdata=0, next request after release completes normally with A priority.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the operand-memory arbiter, its two requesters and the
// dual-bank operand memory.
//   Port A / Port B : Req, We, Sel, Addr, Wdata (requester -> arbiter), Ack (arbiter -> requester)
//   Rdata, Busy     : shared read data and activity flag (arbiter -> requesters)
//   Addr, Data_In, W_En, M_Sel : memory control pins (arbiter -> memory)
//   Data1_O, Data2_O           : bank 0 / bank 1 read data (memory -> arbiter)
interface mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  A_Req;
  logic                  A_We;
  logic                  A_Sel;
  logic [ADDR_WIDTH-1:0] A_Addr;
  logic [DATA_WIDTH-1:0] A_Wdata;
  logic                  A_Ack;

  logic                  B_Req;
  logic                  B_We;
  logic                  B_Sel;
  logic [ADDR_WIDTH-1:0] B_Addr;
  logic [DATA_WIDTH-1:0] B_Wdata;
  logic                  B_Ack;

  logic [DATA_WIDTH-1:0] Rdata;
  logic                  Busy;
  logic [ADDR_WIDTH-1:0] Addr;
  logic [DATA_WIDTH-1:0] Data_In;
  logic                  W_En;
  logic                  M_Sel;
  logic [DATA_WIDTH-1:0] Data1_O;
  logic [DATA_WIDTH-1:0] Data2_O;

  // Arbiter side
  modport slave (
    input  A_Req, A_We, A_Sel, A_Addr, A_Wdata,
    input  B_Req, B_We, B_Sel, B_Addr, B_Wdata,
    input  Data1_O, Data2_O,
    output A_Ack, B_Ack, Rdata, Busy, Addr, Data_In, W_En, M_Sel
  );

  // Requesters plus memory side
  modport master (
    output A_Req, A_We, A_Sel, A_Addr, A_Wdata,
    output B_Req, B_We, B_Sel, B_Addr, B_Wdata,
    output Data1_O, Data2_O,
    input  A_Ack, B_Ack, Rdata, Busy, Addr, Data_In, W_En, M_Sel
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for the shared dual-bank operand memory.
// Serialises single-word reads/writes from port A (operand loader) and
// port B (multiplier operand fetch); all outputs are registered.
//   Clk   : rising-edge clock
//   Rst_n : synchronous active-low reset
//   bus   : mem_arbiter_if.slave (requester handshakes, memory pins, Rdata/Busy)
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input logic          Clk,
  input logic          Rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  state_t                state_q,    state_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  a_ack_q,    a_ack_d;
  logic                  b_ack_q,    b_ack_d;
  logic                  busy_q,     busy_d;
  logic                  w_en_q,     w_en_d;
  logic                  m_sel_q,    m_sel_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [DATA_WIDTH-1:0] data_in_q,  data_in_d;
  logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;

  logic any_req_c;
  logic win_b_c;

  // B wins if it is alone, or if both request and A was granted last
  assign any_req_c = bus.A_Req | bus.B_Req;
  assign win_b_c   = bus.B_Req & (~bus.A_Req | (last_gnt_q == GNT_A));

  // State and output registers
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= GNT_B;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
      w_en_q     <= 1'b0;
      m_sel_q    <= 1'b0;
      addr_q     <= '0;
      data_in_q  <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      busy_q     <= busy_d;
      w_en_q     <= w_en_d;
      m_sel_q    <= m_sel_d;
      addr_q     <= addr_d;
      data_in_q  <= data_in_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next-state logic; in ISSUE, w_en_q still holds the latched We
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req_c) state_d = ST_ISSUE;
      ST_ISSUE: state_d = w_en_q ? ST_ACK : ST_WAIT;
      ST_WAIT:  state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    last_gnt_d = last_gnt_q;
    m_sel_d    = m_sel_q;
    addr_d     = addr_q;
    data_in_d  = data_in_q;
    rdata_d    = rdata_q;
    w_en_d     = 1'b0;
    busy_d     = (state_d != ST_IDLE);
    // last_gnt_q names the port owning the transaction in flight
    a_ack_d    = (state_d == ST_ACK) && (last_gnt_q == GNT_A);
    b_ack_d    = (state_d == ST_ACK) && (last_gnt_q == GNT_B);

    case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          last_gnt_d = win_b_c ? GNT_B : GNT_A;
          if (win_b_c) begin
            w_en_d    = bus.B_We;
            m_sel_d   = bus.B_Sel;
            addr_d    = bus.B_Addr;
            data_in_d = bus.B_Wdata;
          end else begin
            w_en_d    = bus.A_We;
            m_sel_d   = bus.A_Sel;
            addr_d    = bus.A_Addr;
            data_in_d = bus.A_Wdata;
          end
        end
      end
      ST_WAIT:  rdata_d = m_sel_q ? bus.Data2_O : bus.Data1_O;
      default: ;
    endcase
  end

  assign bus.A_Ack   = a_ack_q;
  assign bus.B_Ack   = b_ack_q;
  assign bus.Busy    = busy_q;
  assign bus.W_En    = w_en_q;
  assign bus.M_Sel   = m_sel_q;
  assign bus.Addr    = addr_q;
  assign bus.Data_In = data_in_q;
  assign bus.Rdata   = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural dual-bank memory model.
module tb_mem_arbiter;

  localparam int unsigned DW = 9;
  localparam int unsigned AW = 4;

  logic Clk;
  logic Rst_n;
  int   n_run  = 0;
  int   n_fail = 0;

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory: write on edge with W_En, registered read one cycle after Addr
  logic [DW-1:0] mem0 [16];
  logic [DW-1:0] mem1 [16];

  always @(posedge Clk) begin
    if (bus.W_En) begin
      if (bus.M_Sel) mem1[bus.Addr] <= bus.Data_In;
      else           mem0[bus.Addr] <= bus.Data_In;
    end
    bus.Data1_O <= mem0[bus.Addr];
    bus.Data2_O <= mem1[bus.Addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input bit pb, input bit r, input bit we, input bit sel,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (pb) begin
      bus.B_Req = r; bus.B_We = we; bus.B_Sel = sel; bus.B_Addr = addr; bus.B_Wdata = wd;
    end else begin
      bus.A_Req = r; bus.A_We = we; bus.A_Sel = sel; bus.A_Addr = addr; bus.A_Wdata = wd;
    end
  endtask

  task automatic reset_dut();
    Rst_n = 1'b0;
    bus.A_Req = 1'b0;
    bus.B_Req = 1'b0;
    tick();
    tick();
    Rst_n = 1'b1;
  endtask

  // One transaction from a single requester, checking pins and latency
  task automatic txn(input string tag, input bit pb, input bit we, input bit sel,
                     input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input logic [DW-1:0] exp_rd);
    int cyc;
    logic [DW-1:0] rd_before;
    rd_before = bus.Rdata;
    set_req(pb, 1'b1, we, sel, addr, wd);
    tick();
    cyc = 1;
    chk({tag, "_busy"}, 32'(bus.Busy), 32'd1);
    chk({tag, "_wen"}, 32'(bus.W_En), 32'(we));
    chk({tag, "_addr"}, 32'(bus.Addr), 32'(addr));
    chk({tag, "_msel"}, 32'(bus.M_Sel), 32'(sel));
    if (we) chk({tag, "_din"}, 32'(bus.Data_In), 32'(wd));
    while (!(bus.A_Ack || bus.B_Ack) && cyc < 8) begin
      tick();
      cyc++;
      if (cyc == 2) chk({tag, "_wen_drop"}, 32'(bus.W_En), 32'd0);
    end
    chk({tag, "_lat"}, 32'(cyc), we ? 32'd2 : 32'd3);
    chk({tag, "_own_ack"}, 32'(pb ? bus.B_Ack : bus.A_Ack), 32'd1);
    chk({tag, "_oth_ack"}, 32'(pb ? bus.A_Ack : bus.B_Ack), 32'd0);
    chk({tag, "_rdata"}, 32'(bus.Rdata), we ? 32'(rd_before) : 32'(exp_rd));
    set_req(pb, 1'b0, we, sel, addr, wd);
    tick();
    chk({tag, "_idle_busy"}, 32'(bus.Busy), 32'd0);
    chk({tag, "_idle_ack"}, 32'(bus.A_Ack | bus.B_Ack), 32'd0);
  endtask

  initial begin
    int cyc;
    int nack;
    int last_cyc;
    int lowcnt;

    for (int i = 0; i < 16; i++) begin
      mem0[i] = 9'(i * 3);
      mem1[i] = 9'(9'h100 + i);
    end
    mem0[15] = 9'h055;
    bus.A_Req = 1'b0; bus.A_We = 1'b0; bus.A_Sel = 1'b0; bus.A_Addr = '0; bus.A_Wdata = '0;
    bus.B_Req = 1'b0; bus.B_We = 1'b0; bus.B_Sel = 1'b0; bus.B_Addr = '0; bus.B_Wdata = '0;

    // Reset then idle
    reset_dut();
    chk("rst_a_ack", 32'(bus.A_Ack), 32'd0);
    chk("rst_b_ack", 32'(bus.B_Ack), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_wen", 32'(bus.W_En), 32'd0);
    chk("rst_msel", 32'(bus.M_Sel), 32'd0);
    chk("rst_addr", 32'(bus.Addr), 32'd0);
    chk("rst_din", 32'(bus.Data_In), 32'd0);
    chk("rst_rdata", 32'(bus.Rdata), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_wen", 32'(bus.W_En), 32'd0);
      chk("idle_busy", 32'(bus.Busy), 32'd0);
    end

    // Single write then read on port A
    txn("a_wr", 1'b0, 1'b1, 1'b0, 4'd3, 9'd10, 9'd0);
    txn("a_rd", 1'b0, 1'b0, 1'b0, 4'd3, 9'd0, 9'd10);

    // Bank select on port B, then bank-0 read of the same address
    txn("b_wr", 1'b1, 1'b1, 1'b1, 4'd15, 9'h1FF, 9'd0);
    txn("b_rd", 1'b1, 1'b0, 1'b1, 4'd15, 9'd0, 9'h1FF);
    txn("a_rd15", 1'b0, 1'b0, 1'b0, 4'd15, 9'd0, 9'h055);

    // Contention out of reset: A,B,A,B with 4-cycle read spacing
    reset_dut();
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 9'd0);
    set_req(1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 9'd0);
    nack = 0; cyc = 0; last_cyc = 0;
    while (nack < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (bus.A_Ack || bus.B_Ack) begin
        chk("cont_overlap", 32'(bus.A_Ack & bus.B_Ack), 32'd0);
        chk($sformatf("cont_order%0d", nack), 32'(bus.B_Ack), 32'(nack % 2));
        chk($sformatf("cont_rdata%0d", nack), 32'(bus.Rdata),
            (nack % 2 == 1) ? 32'h1FF : 32'd10);
        chk($sformatf("cont_time%0d", nack), 32'(cyc - last_cyc),
            (nack == 0) ? 32'd3 : 32'd4);
        last_cyc = cyc;
        nack++;
        if (nack == 4) begin
          bus.A_Req = 1'b0;
          bus.B_Req = 1'b0;
        end
      end
    end
    chk("cont_count", 32'(nack), 32'd4);
    tick();
    tick();
    chk("cont_end_busy", 32'(bus.Busy), 32'd0);

    // Held single requester: B_Ack every 4 cycles, one idle cycle between
    set_req(1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 9'd0);
    nack = 0; cyc = 0; last_cyc = 0; lowcnt = 0;
    while (nack < 3 && cyc < 30) begin
      tick();
      cyc++;
      if (!bus.Busy) lowcnt++;
      if (bus.B_Ack) begin
        chk($sformatf("held_rdata%0d", nack), 32'(bus.Rdata), 32'h1FF);
        chk($sformatf("held_a_ack%0d", nack), 32'(bus.A_Ack), 32'd0);
        if (nack > 0) begin
          chk($sformatf("held_gap%0d", nack), 32'(cyc - last_cyc), 32'd4);
          chk($sformatf("held_busy_low%0d", nack), 32'(lowcnt), 32'd1);
        end
        lowcnt = 0;
        last_cyc = cyc;
        nack++;
        if (nack == 3) bus.B_Req = 1'b0;
      end
    end
    chk("held_count", 32'(nack), 32'd3);
    tick();

    // Reset while in WAIT aborts the read
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 9'd0);
    tick();
    tick();
    Rst_n = 1'b0;
    bus.A_Req = 1'b0;
    tick();
    chk("mid_rst_a_ack", 32'(bus.A_Ack), 32'd0);
    chk("mid_rst_rdata", 32'(bus.Rdata), 32'd0);
    chk("mid_rst_busy", 32'(bus.Busy), 32'd0);
    Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_ack", 32'(bus.A_Ack | bus.B_Ack), 32'd0);
    end
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 9'd0);
    set_req(1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 9'd0);
    cyc = 0;
    while (!(bus.A_Ack || bus.B_Ack) && cyc < 8) begin
      tick();
      cyc++;
    end
    chk("post_rst_lat", 32'(cyc), 32'd3);
    chk("post_rst_a_ack", 32'(bus.A_Ack), 32'd1);
    chk("post_rst_b_ack", 32'(bus.B_Ack), 32'd0);
    chk("post_rst_rdata", 32'(bus.Rdata), 32'd10);
    bus.A_Req = 1'b0;
    bus.B_Req = 1'b0;
    tick();
    tick();
    chk("final_busy", 32'(bus.Busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
